// File: rtl/safety_pkg.sv
// Shared definitions for the safety interlock: FSM state encoding and the
// bit positions of the four checker fail flags inside the fault vectors.
package safety_pkg;

  typedef enum logic [2:0] {
    ST_SAFE     = 3'd0,
    ST_ARMING   = 3'd1,
    ST_ARMED    = 3'd2,
    ST_TRIPPED  = 3'd3,
    ST_CLEARING = 3'd4
  } state_e;

  localparam int FLT_LOWER   = 0;
  localparam int FLT_UPPER   = 1;
  localparam int FLT_RATE    = 2;
  localparam int FLT_CURRENT = 3;

  localparam int FLT_W = 4;

endpackage

// File: rtl/fault_recorder.sv
// Host-visible fault bookkeeping: sticky OR of raw fails, first-fault
// snapshot taken on a trip, and a saturating trip counter.
module fault_recorder
  import safety_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             trip_event,
  input  logic             clear_event,
  input  logic [FLT_W-1:0] fail_raw,
  input  logic [FLT_W-1:0] fail_trip,
  output logic [FLT_W-1:0] fault_sticky,
  output logic [FLT_W-1:0] first_fault,
  output logic [CNT_W-1:0] trip_count
);

  logic [FLT_W-1:0] sticky_q, sticky_d;
  logic [FLT_W-1:0] first_q, first_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for the three records; a clear wins over accumulation.
  always_comb begin
    sticky_d = sticky_q | fail_raw;
    first_d  = first_q;
    count_d  = count_q;
    if (clear_event) begin
      sticky_d = '0;
      first_d  = '0;
    end else if (trip_event && (first_q == '0)) begin
      // Only the earliest trip since the last clear is kept.
      first_d = fail_trip;
    end
    if (trip_event && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Record registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sticky_q <= '0;
      first_q  <= '0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      first_q  <= first_d;
      count_q  <= count_d;
    end
  end

  assign fault_sticky = sticky_q;
  assign first_fault  = first_q;
  assign trip_count   = count_q;

endmodule

// File: rtl/safety_interlock.sv
// Laser-permit interlock: arm / trip / clear sequencing downstream of the
// pulse/current limit checker. safety_ok is high only in ARMED.
// Optional build macro SAFETY_FAULT_MASK_EN adds a fault_mask input that
// hides selected fail bits from the trip decision (sticky still sees them).
module safety_interlock
  import safety_pkg::*;
#(
  parameter int ARM_DELAY  = 1000,
  parameter int CLEAR_HOLD = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             arm_req,
  input  logic             clear_req,
  input  logic             pulse_lower_limit_fail,
  input  logic             pulse_upper_limit_fail,
  input  logic             rate_lower_limit_fail,
  input  logic             current_limit_fail,
`ifdef SAFETY_FAULT_MASK_EN
  input  logic [3:0]       fault_mask,
`endif
  output logic             clear_fail,
  output logic             safety_ok,
  output logic [2:0]       state,
  output logic [3:0]       fault_sticky,
  output logic [3:0]       first_fault,
  output logic [CNT_W-1:0] trip_count
);

  localparam int TMR_MAX = (ARM_DELAY > CLEAR_HOLD) ? ARM_DELAY : CLEAR_HOLD;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] ARM_LAST   = TMR_W'(ARM_DELAY - 1);
  localparam logic [TMR_W-1:0] CLEAR_LAST = TMR_W'(CLEAR_HOLD - 1);

  state_e           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             safety_ok_q;
  logic             clear_fail_q;

  logic [FLT_W-1:0] fail_raw;
  logic [FLT_W-1:0] fail_eff;
  logic             fail_any;
  logic             trip_event;
  logic             clear_event;

  // Gather the checker flags into the shared fault-vector layout.
  always_comb begin
    fail_raw              = '0;
    fail_raw[FLT_LOWER]   = pulse_lower_limit_fail;
    fail_raw[FLT_UPPER]   = pulse_upper_limit_fail;
    fail_raw[FLT_RATE]    = rate_lower_limit_fail;
    fail_raw[FLT_CURRENT] = current_limit_fail;
  end

`ifdef SAFETY_FAULT_MASK_EN
  assign fail_eff = fail_raw & ~fault_mask;
`else
  assign fail_eff = fail_raw;
`endif

  // The OR feeds the state register directly so a fail costs one clock.
  assign fail_any = |fail_eff;

  // Recorder strobes, derived from the current state and inputs.
  always_comb begin
    trip_event  = 1'b0;
    clear_event = 1'b0;
    case (state_q)
      ST_SAFE, ST_ARMING, ST_ARMED: trip_event  = fail_any;
      ST_CLEARING:                  clear_event = (tmr_q == CLEAR_LAST) && !fail_any;
      default: ;
    endcase
  end

  // Interlock FSM with shared timer and registered permit / clear strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_SAFE;
      tmr_q        <= '0;
      safety_ok_q  <= 1'b0;
      clear_fail_q <= 1'b0;
    end else begin
      safety_ok_q  <= 1'b0;
      clear_fail_q <= 1'b0;
      case (state_q)
        ST_SAFE: begin
          // A fail beats a simultaneous arm request; clear_req is a no-op here.
          if (fail_any) begin
            state_q <= ST_TRIPPED;
          end else if (arm_req) begin
            state_q <= ST_ARMING;
            tmr_q   <= '0;
          end
        end
        ST_ARMING: begin
          if (fail_any) begin
            state_q <= ST_TRIPPED;
          end else if (tmr_q == ARM_LAST) begin
            state_q     <= ST_ARMED;
            safety_ok_q <= 1'b1;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        ST_ARMED: begin
          if (fail_any) begin
            state_q <= ST_TRIPPED;
          end else begin
            safety_ok_q <= 1'b1;
          end
        end
        ST_TRIPPED: begin
          if (clear_req) begin
            state_q      <= ST_CLEARING;
            tmr_q        <= '0;
            clear_fail_q <= 1'b1;
          end
        end
        ST_CLEARING: begin
          // Fails are only judged on the last cycle of the clear strobe.
          if (tmr_q == CLEAR_LAST) begin
            state_q <= fail_any ? ST_TRIPPED : ST_SAFE;
          end else begin
            tmr_q        <= tmr_q + TMR_W'(1);
            clear_fail_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_TRIPPED;
        end
      endcase
    end
  end

  assign safety_ok  = safety_ok_q;
  assign clear_fail = clear_fail_q;
  assign state      = state_q;

  fault_recorder #(
    .CNT_W(CNT_W)
  ) u_recorder (
    .clk          (clk),
    .rstn         (rstn),
    .trip_event   (trip_event),
    .clear_event  (clear_event),
    .fail_raw     (fail_raw),
    .fail_trip    (fail_eff),
    .fault_sticky (fault_sticky),
    .first_fault  (first_fault),
    .trip_count   (trip_count)
  );

endmodule

// File: tb/tb_safety_interlock.sv
// Directed bench for safety_interlock: a default-parameter instance for the
// main sequences and a small-counter instance for trip-count saturation.
module tb_safety_interlock;

  logic        clk = 1'b0;
  logic        rstn;
  logic        arm_req, clear_req;
  logic        f_lower, f_upper, f_rate, f_current;
  logic        clear_fail, safety_ok;
  logic [2:0]  state;
  logic [3:0]  fault_sticky, first_fault;
  logic [15:0] trip_count;

  logic        s_arm, s_clear, s_fail;
  logic        s_clear_fail, s_safety_ok;
  logic [2:0]  s_state;
  logic [3:0]  s_sticky, s_first;
  logic [2:0]  s_count;

`ifdef SAFETY_FAULT_MASK_EN
  logic [3:0]  fault_mask;
`endif

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  safety_interlock dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .arm_req                (arm_req),
    .clear_req              (clear_req),
    .pulse_lower_limit_fail (f_lower),
    .pulse_upper_limit_fail (f_upper),
    .rate_lower_limit_fail  (f_rate),
    .current_limit_fail     (f_current),
`ifdef SAFETY_FAULT_MASK_EN
    .fault_mask             (fault_mask),
`endif
    .clear_fail             (clear_fail),
    .safety_ok              (safety_ok),
    .state                  (state),
    .fault_sticky           (fault_sticky),
    .first_fault            (first_fault),
    .trip_count             (trip_count)
  );

  safety_interlock #(
    .ARM_DELAY  (4),
    .CLEAR_HOLD (2),
    .CNT_W      (3)
  ) dut_s (
    .clk                    (clk),
    .rstn                   (rstn),
    .arm_req                (s_arm),
    .clear_req              (s_clear),
    .pulse_lower_limit_fail (s_fail),
    .pulse_upper_limit_fail (1'b0),
    .rate_lower_limit_fail  (1'b0),
    .current_limit_fail     (1'b0),
`ifdef SAFETY_FAULT_MASK_EN
    .fault_mask             (4'b0000),
`endif
    .clear_fail             (s_clear_fail),
    .safety_ok              (s_safety_ok),
    .state                  (s_state),
    .fault_sticky           (s_sticky),
    .first_fault            (s_first),
    .trip_count             (s_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, landing 1 ns after the last rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // From TRIPPED with fails low: pulse clear_req and wait the hold out.
  task automatic do_clear();
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    step(16);
  endtask

  initial begin
    int n;
    logic seen_ok;

    rstn = 1'b0;
    arm_req = 0; clear_req = 0;
    f_lower = 0; f_upper = 0; f_rate = 0; f_current = 0;
    s_arm = 0; s_clear = 0; s_fail = 0;
`ifdef SAFETY_FAULT_MASK_EN
    fault_mask = 4'b0000;
`endif
    step(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_safety_ok", 32'(safety_ok), 32'd0);
    chk("rst_clear_fail", 32'(clear_fail), 32'd0);
    chk("rst_sticky", 32'(fault_sticky), 32'd0);
    chk("rst_first", 32'(first_fault), 32'd0);
    chk("rst_count", 32'(trip_count), 32'd0);
    rstn = 1'b1;
    step(8);

    // Arm with no fails: ARMED exactly 1000 clocks after ARMING entry.
    arm_req = 1'b1;
    step(1);
    arm_req = 1'b0;
    chk("arming_entry", 32'(state), 32'd1);
    step(999);
    chk("arming_999_state", 32'(state), 32'd1);
    chk("arming_999_ok", 32'(safety_ok), 32'd0);
    step(1);
    chk("armed_state", 32'(state), 32'd2);
    chk("armed_ok", 32'(safety_ok), 32'd1);
    chk("armed_count", 32'(trip_count), 32'd0);

    // arm_req in ARMED is ignored.
    arm_req = 1'b1;
    step(1);
    arm_req = 1'b0;
    chk("armed_arm_ignored", 32'(state), 32'd2);

    // One-cycle upper fail trips on the next edge.
    f_upper = 1'b1;
    step(1);
    f_upper = 1'b0;
    chk("trip_ok_low", 32'(safety_ok), 32'd0);
    chk("trip_state", 32'(state), 32'd3);
    chk("trip_first", 32'(first_fault), 32'h2);
    chk("trip_sticky", 32'(fault_sticky), 32'h2);
    chk("trip_count1", 32'(trip_count), 32'd1);

    // arm_req in TRIPPED is ignored.
    arm_req = 1'b1;
    step(1);
    arm_req = 1'b0;
    chk("tripped_arm_ignored", 32'(state), 32'd3);

    // Clear with fails low: strobe lasts 16 clocks, then SAFE.
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    chk("clearing_state", 32'(state), 32'd4);
    n = clear_fail ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (clear_fail) n++;
      else break;
    end
    chk("clear_fail_len", 32'(n), 32'd16);
    chk("cleared_state", 32'(state), 32'd0);
    chk("cleared_sticky", 32'(fault_sticky), 32'd0);
    chk("cleared_first", 32'(first_fault), 32'd0);
    chk("cleared_count", 32'(trip_count), 32'd1);

    // clear_req in SAFE is a no-op.
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    chk("safe_clear_noop", 32'(state), 32'd0);

    // Fail together with arm_req in SAFE: fail wins.
    arm_req = 1'b1; f_current = 1'b1;
    step(1);
    arm_req = 1'b0;
    chk("arm_fail_state", 32'(state), 32'd3);
    chk("arm_fail_count", 32'(trip_count), 32'd2);
    chk("arm_fail_first", 32'(first_fault), 32'h8);

    // Clear with current fail held: back to TRIPPED, no extra count.
    clear_req = 1'b1;
    step(1);
    clear_req = 1'b0;
    step(15);
    chk("clear_hold_state", 32'(state), 32'd4);
    chk("clear_hold_strobe", 32'(clear_fail), 32'd1);
    step(1);
    chk("reclear_state", 32'(state), 32'd3);
    chk("reclear_strobe", 32'(clear_fail), 32'd0);
    chk("reclear_count", 32'(trip_count), 32'd2);
    chk("reclear_sticky3", 32'(fault_sticky[3]), 32'd1);
    f_current = 1'b0;
    do_clear();
    chk("back_safe", 32'(state), 32'd0);

    // Rate fail at ARMING count 500: trips, permit never seen.
    arm_req = 1'b1;
    step(1);
    arm_req = 1'b0;
    seen_ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      seen_ok = seen_ok | safety_ok;
    end
    f_rate = 1'b1;
    step(1);
    f_rate = 1'b0;
    seen_ok = seen_ok | safety_ok;
    chk("arming_trip_state", 32'(state), 32'd3);
    chk("arming_trip_ok_seen", 32'(seen_ok), 32'd0);
    chk("arming_trip_first", 32'(first_fault), 32'h4);
    chk("arming_trip_count", 32'(trip_count), 32'd3);
    do_clear();

    // Saturation on the small-counter instance: 9 trips, count pins at 7.
    for (int i = 0; i < 9; i++) begin
      s_fail = 1'b1;
      step(1);
      s_fail = 1'b0;
      s_clear = 1'b1;
      step(1);
      s_clear = 1'b0;
      step(3);
    end
    chk("sat_count", 32'(s_count), 32'd7);
    chk("sat_state", 32'(s_state), 32'd0);

    // Re-arm the main instance, then drop reset between edges.
    arm_req = 1'b1;
    step(1);
    arm_req = 1'b0;
    step(1000);
    chk("rearm_ok", 32'(safety_ok), 32'd1);
`ifdef SAFETY_FAULT_MASK_EN
    fault_mask = 4'b1000; f_current = 1'b1;
    step(3);
    chk("mask_ok_held", 32'(safety_ok), 32'd1);
    chk("mask_state", 32'(state), 32'd2);
    chk("mask_sticky", 32'(fault_sticky), 32'h8);
    f_current = 1'b0; fault_mask = 4'b0000;
`endif
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_ok", 32'(safety_ok), 32'd0);
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_count", 32'(trip_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
